// File: rtl/imem_pkg.sv
// Shared constants for the ifmap memory scheduler: packet layout, opcodes,
// array geometry and the scheduler state encoding.
package imem_pkg;

  localparam int IFMAP_SIZE = 25;
  localparam int NUM_PE     = 5;

  localparam int PKT_W        = 33;
  localparam int PKT_DEST_MSB = 32;
  localparam int PKT_DEST_LSB = 29;
  localparam int PKT_OP_MSB   = 28;
  localparam int PKT_OP_LSB   = 25;
  localparam int PKT_DATA_MSB = 24;
  localparam int PKT_DATA_LSB = 0;

  // router codes; 5..9 double as the PE addresses in the default build
  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_PPE_INPUT  = 4'd1;
  localparam logic [3:0] OP_PE0        = 4'd5;
  localparam logic [3:0] OP_PE1        = 4'd6;
  localparam logic [3:0] OP_PE2        = 4'd7;
  localparam logic [3:0] OP_PE3        = 4'd8;
  localparam logic [3:0] OP_PE4        = 4'd9;
  localparam logic [3:0] OP_PPE_OUTPUT = 4'd10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BCAST = 3'd1,
    SERVE = 3'd2,
    RD    = 3'd3,
    WAIT  = 3'd4,
    SEND  = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/imem_sched_rr_arb5.sv
// Round-robin arbiter: picks the first unmasked requester starting one
// index above the previous winner.
module rr_arb5 #(
  parameter int N = 5,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [N-1:0] elig;

  always_comb begin
    elig = req & ~mask;
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!vld && elig[(int'(last) + i) % N]) begin
        vld = 1'b1;
        idx = IW'((int'(last) + i) % N);
        gnt[(int'(last) + i) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_sched.sv
// Ifmap memory scheduler: broadcasts the first row to each PE, then serves
// per-PE row requests round-robin, packetising each row for the router.
//
// state | meaning
// IDLE  | waiting for start
// BCAST | pick next broadcast row (row k to PE k)
// SERVE | arbitrate PE requests or act on ts_done
// RD    | memory read strobe
// WAIT  | capture read data into packet
// SEND  | hold packet until router accepts
// DONE  | both timesteps finished, waiting for start
module imem_sched #(
  parameter int          IFMAP_SIZE   = imem_pkg::IFMAP_SIZE,
  parameter int          NUM_PE       = imem_pkg::NUM_PE,
  parameter int          PE_BASE_ID   = 5,
  parameter logic [3:0]  OP_PPE_INPUT = imem_pkg::OP_PPE_INPUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ts_done,
  input  logic [NUM_PE-1:0]     req,
  output logic [NUM_PE-1:0]     grant,
  output logic                  rd_en,
  output logic                  rd_ts,
  output logic [4:0]            rd_row,
  input  logic [IFMAP_SIZE-1:0] rd_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [32:0]           pkt_data,
  output logic                  busy,
  output logic                  err
);

  import imem_pkg::*;

  localparam int ROWS_PER_PE = IFMAP_SIZE / NUM_PE;
  localparam int CW = $clog2(ROWS_PER_PE + 1);
  localparam int IW = $clog2(NUM_PE);
  localparam int BW = $clog2(NUM_PE + 1);

  state_t state, state_nx;

  logic [NUM_PE-1:0][CW-1:0] cnt;
  logic [NUM_PE-1:0]         mask;
  logic [IW-1:0]             last, pe_sel, arb_idx;
  logic [BW-1:0]             bc_idx;
  logic [NUM_PE-1:0]         arb_gnt;
  logic                      arb_vld;
  logic                      ts, ts_pend, ts_hit, latch_st;
  logic                      ld_start, ld_bcast, ld_grant, ld_data, ts_act;

  always_comb begin
    for (int k = 0; k < NUM_PE; k++) mask[k] = (cnt[k] == CW'(ROWS_PER_PE));
  end

  rr_arb5 #(.N(NUM_PE)) u_arb (
    .req  (req),
    .mask (mask),
    .last (last),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .vld  (arb_vld)
  );

  assign ts_hit   = ts_pend | ts_done;
  assign latch_st = (state == BCAST) || (state == RD) || (state == WAIT) || (state == SEND);
  assign rd_ts    = ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant     = '0;
    rd_en     = 1'b0;
    pkt_valid = 1'b0;
    busy      = 1'b1;
    ld_start  = 1'b0;
    ld_bcast  = 1'b0;
    ld_grant  = 1'b0;
    ld_data   = 1'b0;
    ts_act    = 1'b0;
    case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        if (start) begin
          ld_start = 1'b1;
          state_nx = BCAST;
        end
      end
      BCAST: begin
        ld_bcast = 1'b1;
        state_nx = RD;
      end
      SERVE: begin
        if (ts_hit) begin
          ts_act   = 1'b1;
          state_nx = ts ? DONE : BCAST;
        end else if (arb_vld) begin
          grant    = arb_gnt;
          ld_grant = 1'b1;
          state_nx = RD;
        end
      end
      RD: begin
        rd_en    = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        ld_data  = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        pkt_valid = 1'b1;
        if (pkt_ready) begin
          // a pending timestep end preempts any remaining work
          if (ts_hit) begin
            ts_act   = 1'b1;
            state_nx = ts ? DONE : BCAST;
          end else if (bc_idx != BW'(NUM_PE)) begin
            state_nx = BCAST;
          end else begin
            state_nx = SERVE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bc_idx   <= '0;
      ts       <= 1'b0;
      ts_pend  <= 1'b0;
      last     <= IW'(NUM_PE - 1);
      pe_sel   <= '0;
      rd_row   <= '0;
      pkt_data <= '0;
      err      <= 1'b0;
    end else begin
      if (ld_start || (ts_act && !ts)) begin
        cnt    <= '0;
        bc_idx <= '0;
      end
      if (ld_start)            ts <= 1'b0;
      else if (ts_act && !ts)  ts <= 1'b1;

      if (ld_start || ts_act)        ts_pend <= 1'b0;
      else if (ts_done && latch_st)  ts_pend <= 1'b1;

      if (ld_bcast) begin
        pe_sel                <= bc_idx[IW-1:0];
        rd_row                <= 5'(bc_idx);
        cnt[bc_idx[IW-1:0]]   <= CW'(1);
        bc_idx                <= bc_idx + BW'(1);
      end

      if (ld_grant) begin
        pe_sel       <= arb_idx;
        last         <= arb_idx;
        rd_row       <= 5'(int'(arb_idx) + NUM_PE * int'(cnt[arb_idx]));
        cnt[arb_idx] <= cnt[arb_idx] + CW'(1);
      end

      if (ld_data) begin
        pkt_data[PKT_DEST_MSB:PKT_DEST_LSB] <= 4'(PE_BASE_ID + int'(pe_sel));
        pkt_data[PKT_OP_MSB:PKT_OP_LSB]     <= OP_PPE_INPUT;
        pkt_data[PKT_DATA_MSB:PKT_DATA_LSB] <= rd_data;
      end

      if ((state == SERVE) && |(req & mask)) err <= 1'b1;
    end
  end

endmodule

// File: doc/imem_sched.md
IMEM_SCHED -- requirements
Module: imem_sched

Interface
REQ-001 Parameter IFMAP_SIZE, default 25, is the ifmap row width in bits and the row count per timestep.
REQ-002 Parameter NUM_PE, default 5, is the number of partial-product engines served.
REQ-003 Parameter PE_BASE_ID, default 5, is the router address of PE index 0; PE k has address PE_BASE_ID+k.
REQ-004 Parameter OP_PPE_INPUT, default 1, is the opcode placed in every issued packet.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port start, input, 1 bit: single-cycle pulse meaning weights are loaded and timestep 1 may begin.
REQ-008 Port ts_done, input, 1 bit: single-cycle pulse meaning the current timestep's compute is finished.
REQ-009 Port req, input, NUM_PE bits: level requests for the next row, held high by PE k until grant[k] is seen.
REQ-010 Port grant, output, NUM_PE bits: one-hot, single-cycle acknowledgement of the accepted request.
REQ-011 Port rd_en, output, 1 bit: memory read strobe.
REQ-012 Port rd_ts, output, 1 bit: timestep select for the read (0 = ts1, 1 = ts2).
REQ-013 Port rd_row, output, 5 bits: row index for the read.
REQ-014 Port rd_data, input, IFMAP_SIZE bits: row data, valid exactly one cycle after rd_en.
REQ-015 Port pkt_valid, output, 1 bit: an issued packet is valid.
REQ-016 Port pkt_ready, input, 1 bit: the router accepts the packet.
REQ-017 Port pkt_data, output, 33 bits: [32:29] destination, [28:25] opcode, [24:0] row data.
REQ-018 Port busy, output, 1 bit: high in every state other than IDLE and DONE.
REQ-019 Port err, output, 1 bit: sticky flag set when a request arrives from a PE that has already received all its rows.

Function
REQ-020 The state machine shall have the states IDLE, BCAST, SERVE, RD, WAIT, SEND, and DONE.
REQ-021 IDLE: on start, set ts to 0, clear all row counters, and go to BCAST.
REQ-022 BCAST: issue rows 0 through NUM_PE-1 in order to PE 0 through NUM_PE-1 using RD, WAIT, SEND, setting each PE's counter to 1, then go to SERVE.
REQ-023 SERVE: with no pending ts_done, pick a requester by round-robin starting one index above the last grant.
REQ-024 SERVE grant: assert grant[k] for one cycle, set rd_row = k + NUM_PE*cnt[k], increment cnt[k], and go to RD.
REQ-025 RD asserts rd_en for exactly one cycle; WAIT captures rd_data into pkt_data[24:0].
REQ-026 SEND holds pkt_valid high until pkt_ready; the transfer completes on the edge where both are high.
REQ-027 Latency: pkt_valid rises 3 cycles after the grant edge.
REQ-028 pkt_data shall remain stable while pkt_valid is high and pkt_ready is low.
REQ-029 After SEND completes, return to BCAST if broadcast rows remain, otherwise to SERVE.
REQ-030 ts_done arriving in any of BCAST, RD, WAIT, or SEND shall be latched and acted on once the current packet is accepted.
REQ-031 ts_done with ts=0: set ts to 1, clear the counters, and go to BCAST.
REQ-032 ts_done with ts=1: go to DONE.
REQ-033 DONE: on start, behave as IDLE does on start.
REQ-034 Exhausted PE (cnt[k] equal to IFMAP_SIZE/NUM_PE): mask its req, never grant it, and set err.
REQ-035 req is ignored outside SERVE; start is ignored outside IDLE and DONE.
REQ-036 When start and ts_done arrive in the same cycle in IDLE, start wins and ts_done is dropped.

Reset
REQ-037 While rst is high, go to IDLE and drive all outputs to 0, including grant, rd_en, pkt_valid, pkt_data, busy, and err.
REQ-038 While rst is high, clear all row counters, ts, the round-robin pointer (last grant = NUM_PE-1), and any latched ts_done.
REQ-039 Reset asserted mid-packet abandons the packet; the router must discard any packet whose handshake did not complete.

Structure
REQ-040 The packet field positions, the opcode constants (0, 1, 5-9, 10), IFMAP_SIZE, NUM_PE, and the state enum shall live in the shared package imem_pkg.
REQ-041 The round-robin arbiter shall be a separate sub-module, rr_arb5, with inputs req and mask, and outputs a one-hot grant and the granted index.

Verification
REQ-042 Broadcast: start, with pkt_ready tied high, yields 5 packets with destinations 5 through 9, rows 0 through 4, opcode 1, and rd_ts=0.
REQ-043 Round-robin: after broadcast, req=5'b11111 held high yields grants in the order 0,1,2,3,4,0,... with rows 5,6,7,8,9,10,...
REQ-044 Back-pressure: pkt_ready low for 10 cycles keeps pkt_valid=1 with pkt_data unchanged; no new grant is issued.
REQ-045 Exhaustion: PE 2 requests after receiving rows 2, 7, 12, 17, and 22 -> no grant to PE 2 and err=1; other PEs are still served.
REQ-046 Timestep: ts_done during SEND -> the current packet completes, then BCAST issues rows 0 through 4 with rd_ts=1; a second ts_done -> DONE with busy=0.
REQ-047 Reset: rst pulsed during WAIT -> all outputs go to 0 in the same cycle, the state is IDLE, and the next start re-broadcasts from row 0.
